// File: rtl/param_router.sv
// param_router: N-port flit router with per-input FIFOs, per-output holding registers
// and per-output round-robin arbiters. Define ROUTER_STATS_EN to add flit/drop counters.
module param_router #(
  parameter int ROUTERID  = 0,
  parameter int NUM_PORTS = 4,
  parameter int DATA_W    = 8,
  parameter int IB_DEPTH  = 4,
  localparam int PORT_W   = $clog2(NUM_PORTS)
) (
  input  logic                              clock,
  input  logic                              reset,
  input  logic [NUM_PORTS-1:0]              put_inbound,
  input  logic [NUM_PORTS-1:0][DATA_W-1:0]  payload_inbound,
  output logic [NUM_PORTS-1:0]              free_inbound,
  input  logic [NUM_PORTS-1:0]              free_outbound,
  output logic [NUM_PORTS-1:0]              put_outbound,
  output logic [NUM_PORTS-1:0][DATA_W-1:0]  payload_outbound,
  output logic                              bad_dest,
  output logic [PORT_W-1:0]                 bad_dest_src
`ifdef ROUTER_STATS_EN
  ,
  output logic [NUM_PORTS-1:0][15:0]        flit_count,
  output logic [7:0]                        drop_count
`endif
);

  localparam int PTR_W = $clog2(IB_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(IB_DEPTH);

  if (NUM_PORTS < 2 || NUM_PORTS > 16 || DATA_W < PORT_W + 1 || IB_DEPTH < 2 ||
      (IB_DEPTH & (IB_DEPTH - 1)) != 0 || ROUTERID < 0) begin : g_param_check
    $error("param_router %0d: illegal parameter set", ROUTERID);
  end

  logic [NUM_PORTS-1:0]              head_valid;
  logic [NUM_PORTS-1:0]              head_bad;
  logic [NUM_PORTS-1:0]              pop;
  logic [NUM_PORTS-1:0][DATA_W-1:0]  head_data;
  logic [NUM_PORTS-1:0][PORT_W-1:0]  head_dest;
  logic [NUM_PORTS-1:0]              gnt_valid;
  logic [NUM_PORTS-1:0][PORT_W-1:0]  gnt_idx;
  logic [PORT_W-1:0]                 bad_first;

  // Input FIFOs: head is read combinationally so a flit written in cycle 0 can be
  // arbitrated in cycle 1.
  for (genvar gi = 0; gi < NUM_PORTS; gi++) begin : g_in
    logic [DATA_W-1:0] mem [IB_DEPTH];
    logic [PTR_W-1:0]  rd_ptr_reg;
    logic [PTR_W-1:0]  wr_ptr_reg;
    logic [CNT_W-1:0]  count_reg;
    logic              wr_en;

    assign free_inbound[gi] = (count_reg != FULL_CNT);
    assign wr_en            = put_inbound[gi] & free_inbound[gi];
    assign head_valid[gi]   = (count_reg != '0);
    assign head_data[gi]    = mem[rd_ptr_reg];
    assign head_dest[gi]    = head_data[gi][DATA_W-1 -: PORT_W];
    assign head_bad[gi]     = head_valid[gi] & (int'({1'b0, head_dest[gi]}) >= NUM_PORTS);

    always_ff @(posedge clock) begin
      if (wr_en) begin
        mem[wr_ptr_reg] <= payload_inbound[gi];
      end
    end

    always_ff @(posedge clock) begin
      if (reset) begin
        rd_ptr_reg <= '0;
        wr_ptr_reg <= '0;
        count_reg  <= '0;
      end else begin
        if (wr_en) begin
          wr_ptr_reg <= wr_ptr_reg + 1'b1;
        end
        if (pop[gi]) begin
          rd_ptr_reg <= rd_ptr_reg + 1'b1;
        end
        count_reg <= count_reg + CNT_W'(wr_en) - CNT_W'(pop[gi]);
      end
    end
  end

  // Per-output round-robin arbiter and single-entry holding register.
  for (genvar gi = 0; gi < NUM_PORTS; gi++) begin : g_out
    logic [NUM_PORTS-1:0] req;
    logic                 ready;
    logic                 gv;
    logic [PORT_W-1:0]    gx;
    logic [PORT_W-1:0]    ptr_reg;
    logic                 valid_reg;
    logic [DATA_W-1:0]    data_reg;

    always_comb begin
      req = '0;
      for (int i = 0; i < NUM_PORTS; i++) begin
        req[i] = head_valid[i] & ~head_bad[i] & (head_dest[i] == PORT_W'(gi));
      end
    end

    assign ready = ~valid_reg | free_outbound[gi];

    always_comb begin
      int idx;
      idx = 0;
      gv  = 1'b0;
      gx  = '0;
      if (ready) begin
        for (int k = 0; k < NUM_PORTS; k++) begin
          idx = int'(ptr_reg) + k;
          if (idx >= NUM_PORTS) begin
            idx = idx - NUM_PORTS;
          end
          if (!gv && req[idx]) begin
            gv = 1'b1;
            gx = PORT_W'(idx);
          end
        end
      end
    end

    always_ff @(posedge clock) begin
      if (reset) begin
        valid_reg <= 1'b0;
        data_reg  <= '0;
        ptr_reg   <= '0;
      end else begin
        if (gv) begin
          valid_reg <= 1'b1;
          data_reg  <= head_data[gx];
          ptr_reg   <= (gx == PORT_W'(NUM_PORTS - 1)) ? '0 : gx + 1'b1;
        end else if (put_outbound[gi]) begin
          valid_reg <= 1'b0;
        end
      end
    end

    assign gnt_valid[gi]        = gv;
    assign gnt_idx[gi]          = gx;
    assign put_outbound[gi]     = valid_reg & free_outbound[gi];
    assign payload_outbound[gi] = data_reg;
  end

  // A head is popped either because it won an output or because it is undeliverable.
  always_comb begin
    pop = head_bad;
    for (int o = 0; o < NUM_PORTS; o++) begin
      if (gnt_valid[o]) begin
        pop[gnt_idx[o]] = 1'b1;
      end
    end
  end

  always_comb begin
    bad_first = '0;
    for (int i = NUM_PORTS - 1; i >= 0; i--) begin
      if (head_bad[i]) begin
        bad_first = PORT_W'(i);
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      bad_dest     <= 1'b0;
      bad_dest_src <= '0;
    end else if (|head_bad && !bad_dest) begin
      bad_dest     <= 1'b1;
      bad_dest_src <= bad_first;
    end
  end

`ifdef ROUTER_STATS_EN
  for (genvar gi = 0; gi < NUM_PORTS; gi++) begin : g_cnt
    logic [15:0] cnt_reg;
    always_ff @(posedge clock) begin
      if (reset) begin
        cnt_reg <= '0;
      end else if (put_outbound[gi] && cnt_reg != 16'hFFFF) begin
        cnt_reg <= cnt_reg + 16'd1;
      end
    end
    assign flit_count[gi] = cnt_reg;
  end

  logic [8:0] drop_sum;
  always_comb begin
    drop_sum = {1'b0, drop_count};
    for (int i = 0; i < NUM_PORTS; i++) begin
      drop_sum = drop_sum + 9'(head_bad[i]);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      drop_count <= '0;
    end else begin
      drop_count <= drop_sum[8] ? 8'hFF : drop_sum[7:0];
    end
  end
`endif

endmodule
